// File: rtl/tile2048_pkg.sv
// tile2048_pkg: shared state encoding, empty-tile value and default sizes for the 2048 row merger
package tile2048_pkg;
    typedef enum logic [1:0] {COLLECT, MERGE, EMIT} state_t;
    localparam int TILE_EMPTY     = 0;
    localparam int DEF_ROW_LEN    = 4;
    localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/tile_merge_step.sv
// tile_merge_step: one combinational slide/merge step of a 2048 row against the pending tile
module tile_merge_step
    import tile2048_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] pending,
    input  logic [DATA_WIDTH-1:0] tile,
    output logic [DATA_WIDTH-1:0] pending_n,
    output logic                  emit,
    output logic [DATA_WIDTH-1:0] emit_val,
    output logic                  merged
);
    localparam logic [DATA_WIDTH-1:0] EMPTY = DATA_WIDTH'(TILE_EMPTY);
    logic tile_empty;
    logic pend_empty;
    always_comb begin
        tile_empty = tile == EMPTY;
        pend_empty = pending == EMPTY;
        emit       = !tile_empty && !pend_empty;
        merged     = emit && pending == tile;
        // clearing pending after a merge keeps the fresh tile from merging again
        pending_n  = tile_empty ? pending : merged ? EMPTY : tile;
        emit_val   = !merged ? pending : (&tile) ? tile : tile + DATA_WIDTH'(1);
    end
endmodule

// File: rtl/row_merge_sequencer.sv
// row_merge_sequencer: collects a row of tiles, slides/merges it, and streams the result back out
module row_merge_sequencer
    import tile2048_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROW_LEN    = DEF_ROW_LEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_tile,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_tile,
    output logic                              out_last,
    output logic                              moved,
    output logic [$clog2(ROW_LEN/2+1)-1:0]    merges
);
    localparam int AW = $clog2(ROW_LEN);
    localparam int SW = $clog2(ROW_LEN + 1);
    localparam int MW = $clog2(ROW_LEN / 2 + 1);
    localparam logic [DATA_WIDTH-1:0] EMPTY      = DATA_WIDTH'(TILE_EMPTY);
    localparam logic [AW-1:0]         LAST_IDX   = AW'(ROW_LEN - 1);
    localparam logic [SW-1:0]         FINAL_STEP = SW'(ROW_LEN);

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d, k_q, k_d, wr_q, wr_d;
    logic [SW-1:0]         step_q, step_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic [DATA_WIDTH-1:0] tiles_q [ROW_LEN];
    logic [DATA_WIDTH-1:0] tiles_d [ROW_LEN];
    logic [DATA_WIDTH-1:0] res_q [ROW_LEN];
    logic [DATA_WIDTH-1:0] res_d [ROW_LEN];
    logic [MW-1:0]         merges_q, merges_d;
    logic                  moved_q, moved_d;
    logic [DATA_WIDTH-1:0] cur_tile, step_pend, step_val;
    logic                  step_emit, step_merged;

    assign cur_tile = step_q == FINAL_STEP ? EMPTY : tiles_q[step_q[AW-1:0]];

    tile_merge_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .pending   (pend_q),
        .tile      (cur_tile),
        .pending_n (step_pend),
        .emit      (step_emit),
        .emit_val  (step_val),
        .merged    (step_merged)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        wr_d     = wr_q;
        step_d   = step_q;
        pend_d   = pend_q;
        tiles_d  = tiles_q;
        res_d    = res_q;
        merges_d = merges_q;
        moved_d  = moved_q;
        case (state_q)
            COLLECT: if (in_valid) begin
                tiles_d[cnt_q] = in_tile;
                cnt_d          = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d  = MERGE;
                    cnt_d    = '0;
                    step_d   = '0;
                    wr_d     = '0;
                    pend_d   = EMPTY;
                    res_d    = '{default: EMPTY};
                    merges_d = '0;
                end
            end
            MERGE: begin
                step_d = step_q + SW'(1);
                if (step_q != FINAL_STEP) begin
                    pend_d = step_pend;
                    if (step_emit) begin
                        res_d[wr_q] = step_val;
                        wr_d        = wr_q + AW'(1);
                    end
                    if (step_merged) merges_d = merges_q + MW'(1);
                end else begin
                    // final step drains pending, then moved compares the finished row
                    if (pend_q != EMPTY) res_d[wr_q] = pend_q;
                    pend_d  = EMPTY;
                    moved_d = 1'b0;
                    for (int i = 0; i < ROW_LEN; i++) moved_d = moved_d | (res_d[i] != tiles_q[i]);
                    state_d = EMIT;
                    k_d     = '0;
                end
            end
            EMIT: if (out_ready) begin
                k_d = k_q + AW'(1);
                if (k_q == LAST_IDX) begin
                    state_d  = COLLECT;
                    k_d      = '0;
                    merges_d = '0;
                    moved_d  = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (flush) begin
            state_d  = COLLECT;
            cnt_d    = '0;
            k_d      = '0;
            step_d   = '0;
            pend_d   = EMPTY;
            merges_d = '0;
            moved_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            k_q      <= '0;
            wr_q     <= '0;
            step_q   <= '0;
            pend_q   <= EMPTY;
            tiles_q  <= '{default: EMPTY};
            res_q    <= '{default: EMPTY};
            merges_q <= '0;
            moved_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            wr_q     <= wr_d;
            step_q   <= step_d;
            pend_q   <= pend_d;
            tiles_q  <= tiles_d;
            res_q    <= res_d;
            merges_q <= merges_d;
            moved_q  <= moved_d;
        end
    end

    assign in_ready  = state_q == COLLECT;
    assign out_valid = state_q == EMIT;
    assign out_tile  = out_valid ? res_q[k_q] : EMPTY;
    assign out_last  = out_valid && k_q == LAST_IDX;
    assign moved     = moved_q;
    assign merges    = merges_q;
endmodule

// File: tb/tb_row_merge_sequencer.sv
// tb_row_merge_sequencer: directed rows with a scoreboard queue checked by an output monitor
module tb_row_merge_sequencer;
    typedef logic [7:0] row_t [4];
    typedef struct {
        logic [7:0] tile;
        logic       last;
        logic       moved;
        logic [1:0] merges;
    } exp_t;

    logic       clk, rst, in_valid, in_ready, flush, out_valid, out_ready, out_last, moved;
    logic [7:0] in_tile, out_tile;
    logic [1:0] merges;
    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;

    row_merge_sequencer #(.DATA_WIDTH(8), .ROW_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tile   (in_tile),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tile  (out_tile),
        .out_last  (out_last),
        .moved     (moved),
        .merges    (merges)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out_tile", out_tile, exp_q[0].tile);
                chk("out_last", out_last, exp_q[0].last);
                chk("moved", moved, exp_q[0].moved);
                chk("merges", merges, exp_q[0].merges);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_exp(input row_t r, input int m, input int mv);
        for (int i = 0; i < 4; i++) exp_q.push_back('{tile: r[i], last: (i == 3), moved: mv[0], merges: m[1:0]});
    endtask

    task automatic feed(input row_t t);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_tile  = t[i];
            chk("in_ready_collect", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_tile  = '0;
    endtask

    task automatic send_row(input row_t t, input row_t r, input int m, input int mv, input int stall_at);
        int n;
        push_exp(r, m, mv);
        feed(t);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 5);
        if (stall_at >= 0) begin
            repeat (stall_at) begin @(posedge clk); #1; end
            out_ready = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("in_ready_after_row", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_tile = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tile", out_tile, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_moved", moved, 0);
        chk("rst_merges", merges, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_row('{8'd1, 8'd1, 8'd0, 8'd0}, '{8'd2, 8'd0, 8'd0, 8'd0}, 1, 1, -1);
        send_row('{8'd1, 8'd1, 8'd1, 8'd1}, '{8'd2, 8'd2, 8'd0, 8'd0}, 2, 1, -1);
        send_row('{8'd2, 8'd0, 8'd2, 8'd2}, '{8'd3, 8'd2, 8'd0, 8'd0}, 1, 1, -1);
        send_row('{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd1, 8'd2, 8'd3, 8'd4}, 0, 0, -1);
        send_row('{8'd255, 8'd255, 8'd0, 8'd0}, '{8'd255, 8'd0, 8'd0, 8'd0}, 1, 1, -1);
        send_row('{8'd0, 8'd0, 8'd0, 8'd3}, '{8'd3, 8'd0, 8'd0, 8'd0}, 0, 1, -1);
        send_row('{8'd3, 8'd3, 8'd3, 8'd0}, '{8'd4, 8'd3, 8'd0, 8'd0}, 1, 1, -1);
        send_row('{8'd2, 8'd2, 8'd4, 8'd0}, '{8'd3, 8'd4, 8'd0, 8'd0}, 1, 1, 1);

        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_tile  = 8'd5;
            @(posedge clk); #1;
        end
        in_tile = 8'd7;
        flush   = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        send_row('{8'd1, 8'd1, 8'd0, 8'd0}, '{8'd2, 8'd0, 8'd0, 8'd0}, 1, 1, -1);

        feed('{8'd1, 8'd1, 8'd0, 8'd0});
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("flush_merge_out_valid", out_valid, 0);
        chk("flush_merge_in_ready", in_ready, 1);

        out_ready = 1'b0;
        push_exp('{8'd1, 8'd2, 8'd3, 8'd4}, 0, 0);
        feed('{8'd1, 8'd2, 8'd3, 8'd4});
        for (int n = 0; n < 20 && !out_valid; n++) begin @(posedge clk); #1; end
        chk("pre_rst_out_valid", out_valid, 1);
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_tile", out_tile, 0);
        chk("async_rst_merges", merges, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send_row('{8'd1, 8'd1, 8'd0, 8'd0}, '{8'd2, 8'd0, 8'd0, 8'd0}, 1, 1, -1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/row_merge_sequencer.md
ROW_MERGE_SEQUENCER -- requirements
Module: row_merge_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one tile value; tile value is a 2048 exponent, 0 = empty.
REQ-002 Parameter ROW_LEN, default 4, number of tiles per row.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_tile holds a valid tile read from the shift-register buffer.
REQ-006 in_ready  output  1  block accepts a tile this cycle.
REQ-007 in_tile  input  DATA_WIDTH  incoming tile; index 0 is the tile nearest the slide direction.
REQ-008 flush  input  1  synchronous abort; discards the partial row.
REQ-009 out_valid  output  1  out_tile holds a valid result tile.
REQ-010 out_ready  input  1  downstream writer accepts out_tile this cycle.
REQ-011 out_tile  output  DATA_WIDTH  merged tile for write-back, index order equals input order.
REQ-012 out_last  output  1  high with the final (ROW_LEN-1) output tile.
REQ-013 moved  output  1  row result differs from input row; valid while out_valid.
REQ-014 merges  output  $clog2(ROW_LEN/2+1)  merge count for the row; valid while out_valid.

Function
REQ-015 FSM states COLLECT, MERGE, EMIT; COLLECT follows reset.
REQ-016 COLLECT: in_ready=1; each in_valid&&in_ready cycle stores in_tile at index cnt, cnt increments; after the ROW_LEN-th tile, go to MERGE.
REQ-017 MERGE lasts exactly ROW_LEN+1 cycles; in_ready=0, out_valid=0.
REQ-018 MERGE step i<ROW_LEN on tile t: t==0 skip; pending empty -> pending=t; pending==t -> emit t+1, clear pending, merges+1; else emit pending, pending=t.
REQ-019 MERGE final step: emit pending if non-empty; unfilled result slots = 0.
REQ-020 Merge of two tiles equal to all-ones saturates at all-ones and still counts as a merge.
REQ-021 A freshly merged tile never merges again in the same row.
REQ-022 moved=1 iff any result slot differs from its input slot; computed before EMIT entry.
REQ-023 EMIT: out_valid=1, out_tile=result[k]; k advances only on out_valid&&out_ready; out_last=1 when k==ROW_LEN-1.
REQ-024 out_tile, out_last, moved, merges stable while out_valid&&!out_ready.
REQ-025 Handshake on the last tile returns to COLLECT next cycle with cnt=0, merges cleared.
REQ-026 in_ready=0 throughout MERGE and EMIT; no overlap of rows.
REQ-027 flush in any state: next cycle state=COLLECT, cnt=0, out_valid=0; flush dominates a simultaneous input or output handshake.
REQ-028 Total latency last input accept -> first out_valid = ROW_LEN+1 cycles.

Reset
REQ-029 On rst: state=COLLECT, cnt=0, k=0, pending empty, tile and result storage=0.
REQ-030 Reset outputs: in_ready=1, out_valid=0, out_tile=0, out_last=0, moved=0, merges=0.
REQ-031 Reset mid-MERGE or mid-EMIT takes effect asynchronously; no partial row survives.

Structure
REQ-032 Shared package tile2048_pkg holds the state enum, TILE_EMPTY constant, and default ROW_LEN/DATA_WIDTH.
REQ-033 One combinational sub-module tile_merge_step (pending, tile -> new pending, emit flag, emit value, merge flag) implements REQ-018/REQ-020.
REQ-034 Target 120-400 lines RTL total.

Verification
REQ-035 Input [1,1,0,0], out_ready=1 -> out [2,0,0,0], merges=1, moved=1, out_last on 4th tile.
REQ-036 Input [1,1,1,1] -> [2,2,0,0], merges=2; input [2,0,2,2] -> [3,2,0,0], merges=1.
REQ-037 Input [1,2,3,4] -> [1,2,3,4], merges=0, moved=0; first out_valid 5 cycles after 4th accept.
REQ-038 Input [255,255,0,0] (DATA_WIDTH=8) -> [255,0,0,0], merges=1.
REQ-039 out_ready low 3 cycles on tile 1 -> out_tile held constant, then sequence resumes unchanged.
REQ-040 flush after 2 tiles, and rst asserted mid-EMIT -> in_ready=1, out_valid=0; next full row [1,1,0,0] yields [2,0,0,0].
